// File: rtl/motor_pkg.sv
// Constants and types shared by the encoder, speed-to-duty and driver stages.
package motor_pkg;

  localparam int PERIOD_W = 32;
  localparam int SPEED_W  = 32;
  localparam int DUTY_W   = 32;

  // Saturated period code meaning "stalled / no motion measured".
  localparam logic signed [PERIOD_W-1:0] PERIOD_MAX = 32'sh7fffffff;

  typedef logic signed [PERIOD_W-1:0] period_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

endpackage

// File: rtl/encoder_period_if.sv
// Output bundle of the encoder period meter towards the speed-to-duty stage.
interface encoder_period_if;
  import motor_pkg::*;

  // period_valid is a one-cycle strobe with no back-pressure: the consumer must
  // take period/direction/edge_count in the cycle the strobe is high.
  period_t            period;
  logic               period_valid;
  dir_e               direction;
  logic signed [31:0] edge_count;
  logic [0:0]         state;

  modport master (output period, output period_valid, output direction,
                  output edge_count, output state);
  modport slave  (input period, input period_valid, input direction,
                  input edge_count, input state);
endinterface

// File: rtl/encoder_period_edge_filter.sv
// One encoder channel: multi-flop synchroniser followed by a run-length debounce.
module edge_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // run_cnt counts consecutive cycles the synchronised input disagrees with
  // level; any agreeing sample restarts the run, so short pulses never land.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      run_cnt <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      if (synced != level) begin
        if (run_cnt == CW'(GLITCH_CYCLES - 1)) begin
          level   <= synced;
          rise    <= synced;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + CW'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/encoder_period.sv
// Quadrature encoder speed meter: signed A-to-A period, stall detection and a
// running signed position count.
module encoder_period #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          GLITCH_CYCLES = 4,
  parameter logic [31:0] TIMEOUT       = 32'd5000000,
  parameter logic [31:0] PERIOD_MAX    = motor_pkg::PERIOD_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  encoder_period_if.master bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic                   a_rise;
  logic                   a_level;
  logic                   b_level;
  logic                   b_rise;
  logic [0:0]             state_q;
  logic [31:0]            cnt_q;
  motor_pkg::period_t     period_q;
  logic                   valid_q;
  motor_pkg::dir_e        dir_q;
  logic signed [31:0]     edge_count_q;
  logic                   timeout_hit;

  edge_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_a),
    .level (a_level),
    .rise  (a_rise)
  );

  edge_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_b),
    .level (b_level),
    .rise  (b_rise)
  );

  // An A event in the same cycle takes priority over declaring a stall.
  assign timeout_hit = (state_q == ST_ARMED) && (cnt_q == TIMEOUT) && !a_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_q     <= motor_pkg::period_t'(PERIOD_MAX);
      valid_q      <= 1'b0;
      dir_q        <= motor_pkg::DIR_FWD;
      edge_count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (a_rise) begin
        dir_q        <= motor_pkg::dir_e'(b_level);
        edge_count_q <= b_level ? edge_count_q - 32'sd1 : edge_count_q + 32'sd1;
        cnt_q        <= 32'd1;
        state_q      <= ST_ARMED;
        if (state_q == ST_ARMED) begin
          period_q <= b_level ? -$signed(cnt_q) : $signed(cnt_q);
          valid_q  <= 1'b1;
        end
      end else if (timeout_hit) begin
        period_q <= motor_pkg::period_t'(PERIOD_MAX);
        valid_q  <= 1'b1;
        state_q  <= ST_IDLE;
      end else if ((state_q == ST_ARMED) && (cnt_q != TIMEOUT)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.direction    = dir_q;
  assign bus.edge_count   = edge_count_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_encoder_period.sv
// Randomised scoreboard bench for encoder_period against an event-level model.
module tb_encoder_period;
  localparam int SYNC    = 2;
  localparam int GLITCH  = 4;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = SYNC + GLITCH + 1;
  localparam int W       = 97;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  encoder_period_if bus();

  encoder_period #(
    .SYNC_STAGES   (SYNC),
    .GLITCH_CYCLES (GLITCH),
    .TIMEOUT       (32'd1000),
    .PERIOD_MAX    (32'h7fffffff)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // entry: {cycle[31:0], period[31:0], edge_count[31:0], direction}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (raw-edge level) ----------------
  bit m_armed = 1'b0;
  int m_last  = 0;
  int m_pos   = 0;
  bit m_dir   = 1'b0;

  function automatic void push(input int cycle, input logic [31:0] per, input int pos, input bit d);
    logic [31:0] c32;
    logic [31:0] p32;
    c32 = cycle;
    p32 = pos;
    exp_q.push_back({c32, per, p32, d});
  endfunction

  // A stall is reported once more than TIMEOUT cycles pass between A edges.
  function automatic void model_advance(input int t);
    if (m_armed && (t - m_last) > TIMEOUT) begin
      push(m_last + TIMEOUT + LAT, 32'h7fffffff, m_pos, m_dir);
      m_armed = 1'b0;
    end
  endfunction

  function automatic void model_edge(input int t, input bit b);
    int gap;
    logic [31:0] pv;
    model_advance(t);
    gap   = t - m_last;
    m_dir = b;
    m_pos = b ? m_pos - 1 : m_pos + 1;
    if (m_armed) begin
      pv = b ? 32'(-gap) : 32'(gap);
      push(t + LAT, pv, m_pos, m_dir);
    end
    m_armed = 1'b1;
    m_last  = t;
  endfunction

  // ---------------- driver ----------------
  int prev_t      = 0;
  bit chk_pending = 1'b0;
  int chk_pos     = 0;
  bit chk_dir     = 1'b0;

  task automatic post_edge_check(input int k);
    if (k == 8 && chk_pending) begin
      chk("edge_count", bus.edge_count, 32'(chk_pos));
      chk("direction", {31'b0, bus.direction}, {31'b0, chk_dir});
      chk_pending = 1'b0;
    end
  endtask

  // Next A rise lands g cycles after the previous one; B settles at k=10,
  // and an optional short glitch on A is placed mid-gap.
  task automatic run_period(input int g, input bit b, input int glen);
    int t;
    t = prev_t + g;
    model_edge(t, b);
    for (int k = 1; k <= g; k++) begin
      @(posedge clk); #1;
      post_edge_check(k);
      if (k == 8) enc_a = 1'b0;
      if (k == 10) enc_b = b;
      if (glen > 0 && k == g / 2) enc_a = 1'b1;
      if (glen > 0 && k == g / 2 + glen) enc_a = 1'b0;
      if (k == g) enc_a = 1'b1;
    end
    prev_t      = t;
    chk_pending = 1'b1;
    chk_pos     = m_pos;
    chk_dir     = m_dir;
  endtask

  task automatic idle(input int n);
    model_advance(prev_t + n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      post_edge_check(k);
      if (k == 8) enc_a = 1'b0;
    end
    prev_t = prev_t + n;
  endtask

  task automatic do_reset(input int n);
    chk("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("reset_period", bus.period, 32'h7fffffff);
        chk("reset_valid", {31'b0, bus.period_valid}, 32'd0);
        chk("reset_direction", {31'b0, bus.direction}, 32'd0);
        chk("reset_edge_count", bus.edge_count, 32'd0);
      end
    end
    reset       = 1'b0;
    m_armed     = 1'b0;
    m_pos       = 0;
    m_dir       = 1'b0;
    chk_pending = 1'b0;
    prev_t      = cyc;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.period_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got period %h at cycle %0d, expected no pulse",
                 bus.period, cyc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), e[96:65]);
        chk("period", bus.period, e[64:33]);
        chk("pulse_edge_count", bus.edge_count, e[32:1]);
        chk("pulse_direction", {31'b0, bus.direction}, {31'b0, e[0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    bit b;
    int glen;
    @(posedge clk); #1;
    do_reset(3);

    // steady forward edges
    repeat (6) run_period(100, 1'b0, 0);
    // reverse edges
    repeat (5) run_period(250, 1'b1, 0);
    // glitch rejection
    run_period(100, 1'b0, 0);
    run_period(100, 1'b0, 3);
    run_period(100, 1'b0, 0);
    // stall, re-arm, measure again
    run_period(100, 1'b0, 0);
    run_period(1100, 1'b0, 0);
    run_period(100, 1'b0, 0);
    // event exactly at timeout wins; one cycle later stalls
    run_period(1000, 1'b1, 0);
    run_period(1001, 1'b0, 0);
    run_period(100, 1'b0, 0);
    // reset mid-measurement
    run_period(100, 1'b0, 0);
    idle(50);
    do_reset(1);
    repeat (3) run_period(100, 1'b0, 0);

    // randomised gaps, directions and glitches
    repeat (30) begin
      g    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(995, 1010))
                                         : int'($urandom_range(24, 600));
      b    = 1'($urandom_range(0, 1));
      glen = (g >= 40 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_period(g, b, glen);
    end
    idle(1200);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encoder_period.md
Name: encoder_period

Overview:
Measures motor shaft speed from a quadrature encoder as a signed period in clock cycles between consecutive rising edges of channel A. It sits directly upstream of the speed-to-duty stage and feeds its signed 32-bit period input. Stall or timeout is reported as the saturated value 32'h7fffffff, which the downstream stage uses for overload clamping. The block also keeps a signed position edge count for the controller.

Parameters:
SYNC_STAGES, 2, flip-flops in each input synchroniser (minimum 2)
GLITCH_CYCLES, 4, consecutive stable synchronised samples required before a filtered level changes (minimum 1)
TIMEOUT, 32'd5000000, cycles without an A event before stall is declared (2 ≤ TIMEOUT < PERIOD_MAX)
PERIOD_MAX, 32'h7fffffff, stall code driven on period

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enc_a  in  1  raw encoder channel A, asynchronous
enc_b  in  1  raw encoder channel B, asynchronous
period  out  32 signed  last measured period; +count = forward, -count = reverse, PERIOD_MAX = stalled
period_valid  out  1  one-cycle pulse when period is updated
direction  out  1  1 = reverse, as sampled at the last A event
edge_count  out  32 signed  running position: +1 per forward A event, -1 per reverse A event, wraps modulo 2^32

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset, next edge: period=PERIOD_MAX, period_valid=0, direction=0, edge_count=0, armed=0, cycle counter=0, filter states=0.
- Reset mid-operation discards any partial measurement. The first A event after reset only arms the block.
- Input path: each of enc_a and enc_b passes through SYNC_STAGES flops, then a debounce filter.
  - The filtered level takes the synchronised value once that value has differed from the current filtered level for GLITCH_CYCLES consecutive cycles.
  - A shorter pulse is rejected and its run counter clears.
- A event: cycle where filtered A goes 0→1.
  - Direction is taken from filtered B in that same cycle: B=0 means forward, B=1 means reverse.
- Cycle counter: increments each cycle while armed and saturates at TIMEOUT. On an A event it reloads to 1.
- On an A event:
  - When armed=1: period = +counter (forward) or -counter (reverse), using the counter value before reload. Pulse period_valid.
  - When armed=0: set armed=1, load the counter, leave period unchanged, no pulse.
  - In both cases, update direction and edge_count ±1.
- Timeout: when armed=1, counter==TIMEOUT and no A event occurs that cycle:
  - period = +PERIOD_MAX (always positive, regardless of direction);
  - period_valid pulses once;
  - armed=0.
  - No further pulses until re-armed.
- Simultaneous A event and timeout condition: the event wins; the timeout is not declared.
- Latency: a clean raw A rising edge gives period_valid exactly SYNC_STAGES + GLITCH_CYCLES + 1 cycles later.
- The magnitude of period is always ≤ TIMEOUT, so it never collides with PERIOD_MAX. Negation is plain two's-complement on the 32-bit value.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package motor_pkg holds:
  - PERIOD_MAX;
  - 32-bit signed period/speed/duty width constants;
  - the forward/reverse direction encoding.
  These are shared with the speed-to-duty and driver stages.
- One sub-module, edge_filter: a synchroniser plus debounce for one bit, parameterised by SYNC_STAGES and GLITCH_CYCLES. It is instantiated twice, once for A and once for B.

Test Plan:
(Benches run with GLITCH_CYCLES=4, SYNC_STAGES=2, TIMEOUT=1000.)
1. Assert reset for 3 cycles, enc_a=enc_b=0 → period=32'h7fffffff, period_valid=0, direction=0, edge_count=0.
2. Drive clean A rising edges every 100 cycles, B=0 at each rise:
   - 1st edge: no pulse, edge_count=1.
   - 2nd and later edges: a period_valid pulse 7 cycles after each raw edge, period=+100, edge_count increments.
3. Drive A every 250 cycles with B=1 → period=-250 (32'hffffff06), direction=1, edge_count decrements by 1 per edge.
4. Drive a 3-cycle glitch high on enc_a between valid edges → no A event, edge_count unchanged, next period still 100.
5. After steady 100-cycle edges, stop A:
   - Exactly 1000 cycles after the last event: period=32'h7fffffff with a single period_valid pulse, then none.
   - Next edge: no pulse (re-arm only).
   - The following edge 100 cycles later: period=+100.
6. Assert reset for 1 cycle 50 cycles into a measurement:
   - Next cycle: all outputs return to their reset values.
   - First subsequent edge gives no pulse; the second edge gives a correct period.
